// File: rtl/mux_scan_sequencer_pkg.sv
// Shared types and reset values for the mux scan sequencer.
package mux_seq_pkg;

   localparam int SEL_W = 4;
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DWELL  = 2'd2
   } seq_state_t;

   // Scan configuration captured when a start is accepted.
   typedef struct packed {
      logic [SEL_W-1:0] first;
      logic [SEL_W-1:0] last;
      logic [CNT_W-1:0] settle;
      logic [CNT_W-1:0] dwell;
      logic             continuous;
   } mux_seq_cfg_t;

   localparam logic [SEL_W-1:0] RST_SEL      = '0;
   localparam logic             RST_TRISTATE = 1'b1;
   localparam logic             RST_FLAG     = 1'b0;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Control/status bundle between register decode (master) and the sequencer (slave).
interface mux_scan_sequencer_if #(
   parameter int SEL_WIDTH = 4,
   parameter int CNT_WIDTH = 16
);
   logic                 start;
   logic                 stop;
   logic [SEL_WIDTH-1:0] cfg_first;
   logic [SEL_WIDTH-1:0] cfg_last;
   logic [CNT_WIDTH-1:0] cfg_settle;
   logic [CNT_WIDTH-1:0] cfg_dwell;
   logic                 cfg_continuous;
   logic [SEL_WIDTH-1:0] sel;
   logic                 tristate;
   logic                 chan_valid;
   logic                 busy;
   logic                 done;
   logic                 cfg_err;

   modport master (
      output start, stop, cfg_first, cfg_last, cfg_settle, cfg_dwell, cfg_continuous,
      input  sel, tristate, chan_valid, busy, done, cfg_err
   );

   modport slave (
      input  start, stop, cfg_first, cfg_last, cfg_settle, cfg_dwell, cfg_continuous,
      output sel, tristate, chan_valid, busy, done, cfg_err
   );
endinterface

// File: rtl/mux_scan_sequencer_counter.sv
// Loadable down-counter that times both the settle and the dwell intervals.
module interval_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             zero
);

   logic [WIDTH-1:0] count_q;

   // Count down to zero and park there until reloaded.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count_q <= '0;
      else if (clear)
         count_q <= '0;
      else if (load)
         count_q <= load_val;
      else if (count_q != '0)
         count_q <= count_q - 1'b1;
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Break-before-make scan sequencer for an N-input mux.
//
// state  | meaning
// IDLE   | mux disabled, waiting for start
// SETTLE | select applied, output still tristated while the mux settles
// DWELL  | channel driven, chan_valid high
module mux_scan_sequencer
   import mux_seq_pkg::*;
#(
   parameter int N_INPUTS  = 2,
   parameter int SEL_WIDTH = SEL_W,
   parameter int CNT_WIDTH = CNT_W
) (
   input  logic               clk,
   input  logic               reset,
   mux_scan_sequencer_if.slave bus
);

   localparam logic [SEL_WIDTH:0] N_LIMIT = N_INPUTS[SEL_WIDTH:0];

   seq_state_t           state_q, state_d;
   mux_seq_cfg_t         cfg_q, cfg_d;
   logic [SEL_WIDTH-1:0] sel_q, sel_d;
   logic                 tristate_q, chan_valid_q, busy_q, done_q, cfg_err_q;
   logic                 done_d, cfg_err_d;
   logic                 cnt_clear, cnt_load, cnt_zero;
   logic [CNT_WIDTH-1:0] cnt_val;
   logic                 cfg_bad;

   assign cfg_bad = (bus.cfg_first > bus.cfg_last) || ({1'b0, bus.cfg_last} >= N_LIMIT);

   interval_counter #(.WIDTH(CNT_WIDTH)) u_interval (
      .clk      (clk),
      .reset    (reset),
      .clear    (cnt_clear),
      .load     (cnt_load),
      .load_val (cnt_val),
      .zero     (cnt_zero)
   );

   // Next-state, select and counter-load decisions; stop overrides everything.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      cfg_d     = cfg_q;
      cnt_clear = 1'b0;
      cnt_load  = 1'b0;
      cnt_val   = '0;
      done_d    = 1'b0;
      cfg_err_d = 1'b0;
      if (bus.stop) begin
         state_d   = IDLE;
         cnt_clear = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  if (cfg_bad) begin
                     cfg_err_d = 1'b1;
                  end else begin
                     cfg_d.first      = bus.cfg_first;
                     cfg_d.last       = bus.cfg_last;
                     cfg_d.settle     = bus.cfg_settle;
                     cfg_d.dwell      = bus.cfg_dwell;
                     cfg_d.continuous = bus.cfg_continuous;
                     sel_d            = bus.cfg_first;
                     state_d          = SETTLE;
                     cnt_load         = 1'b1;
                     cnt_val          = bus.cfg_settle;
                  end
               end
            end
            SETTLE: begin
               if (cnt_zero) begin
                  state_d  = DWELL;
                  cnt_load = 1'b1;
                  cnt_val  = cfg_q.dwell;
               end
            end
            DWELL: begin
               if (cnt_zero) begin
                  if (sel_q != cfg_q.last || cfg_q.continuous) begin
                     sel_d    = (sel_q != cfg_q.last) ? sel_q + 1'b1 : cfg_q.first;
                     state_d  = SETTLE;
                     cnt_load = 1'b1;
                     cnt_val  = cfg_q.settle;
                  end else begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State, latched config and registered outputs derived from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cfg_q        <= '0;
         sel_q        <= RST_SEL;
         tristate_q   <= RST_TRISTATE;
         chan_valid_q <= RST_FLAG;
         busy_q       <= RST_FLAG;
         done_q       <= RST_FLAG;
         cfg_err_q    <= RST_FLAG;
      end else begin
         state_q      <= state_d;
         cfg_q        <= cfg_d;
         sel_q        <= sel_d;
         tristate_q   <= (state_d != DWELL);
         chan_valid_q <= (state_d == DWELL);
         busy_q       <= (state_d != IDLE);
         done_q       <= done_d;
         cfg_err_q    <= cfg_err_d;
      end
   end

   assign bus.sel        = sel_q;
   assign bus.tristate   = tristate_q;
   assign bus.chan_valid = chan_valid_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench: timeline model of the scan plus directed literal checks.
module tb_mux_scan_sequencer;

   localparam int N = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;

   mux_scan_sequencer_if #(.SEL_WIDTH(4), .CNT_WIDTH(16)) bus ();

   mux_scan_sequencer #(.N_INPUTS(N), .SEL_WIDTH(4), .CNT_WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model: a scan is a timeline; cycle t (1 = first cycle after acceptance)
   // maps to channel ((t-1)/P mod K) and phase (t-1) mod P, P = settle+dwell+2.
   bit m_active = 0;
   int m_t = 0, m_first = 0, m_k = 1, m_p = 2, m_settle = 0;
   bit m_cont = 0;
   int m_sel = 0;
   bit m_done = 0, m_err = 0;

   always @(posedge clk or posedge reset) begin
      int phase;
      bit e_tri;
      if (reset) begin
         m_active = 0; m_t = 0; m_sel = 0; m_done = 0; m_err = 0;
      end else begin
         m_done = 0; m_err = 0;
         if (bus.stop) begin
            m_active = 0;
         end else if (!m_active) begin
            if (bus.start) begin
               if (int'(bus.cfg_first) > int'(bus.cfg_last) || int'(bus.cfg_last) >= N) begin
                  m_err = 1;
               end else begin
                  m_first  = int'(bus.cfg_first);
                  m_k      = int'(bus.cfg_last) - m_first + 1;
                  m_settle = int'(bus.cfg_settle);
                  m_p      = m_settle + int'(bus.cfg_dwell) + 2;
                  m_cont   = bus.cfg_continuous;
                  m_active = 1;
                  m_t      = 1;
               end
            end
         end else begin
            m_t++;
            if (!m_cont && m_t > m_k * m_p) begin
               m_active = 0;
               m_done   = 1;
            end
         end
         if (m_active) m_sel = m_first + ((m_t - 1) / m_p) % m_k;
      end
      phase = m_active ? (m_t - 1) % m_p : 0;
      e_tri = !m_active || (phase <= m_settle);
      #1;
      chk("outputs{sel,tri,cv,busy,done,err}",
          int'({bus.sel, bus.tristate, bus.chan_valid, bus.busy, bus.done, bus.cfg_err}),
          int'({4'(m_sel), e_tri, ~e_tri, m_active, m_done, m_err}));
   end

   logic [3:0] o_sel  [0:63];
   bit         o_tri  [0:63];
   bit         o_busy [0:63];
   bit         o_done [0:63];
   bit         o_err  [0:63];

   task automatic do_start(input int f, input int l, input int s, input int d, input bit c,
                           input bit with_stop);
      @(negedge clk);
      bus.cfg_first = 4'(f); bus.cfg_last = 4'(l);
      bus.cfg_settle = 16'(s); bus.cfg_dwell = 16'(d); bus.cfg_continuous = c;
      bus.start = 1'b1; bus.stop = with_stop;
      @(negedge clk);
      bus.start = 1'b0; bus.stop = 1'b0;
   endtask

   // Record outputs of cycles 1..n; optionally pulse stop/start during chosen cycles.
   task automatic capture(input int n, input int stop_at, input int start_at);
      for (int i = 1; i <= n; i++) begin
         o_sel[i] = bus.sel; o_tri[i] = bus.tristate; o_busy[i] = bus.busy;
         o_done[i] = bus.done; o_err[i] = bus.cfg_err;
         bus.stop  = (i == stop_at);
         bus.start = (i == start_at);
         @(negedge clk);
      end
      bus.stop = 1'b0; bus.start = 1'b0;
   endtask

   task automatic check_one_shot(input string tag);
      int ndone;
      logic [7:0] pat;
      ndone = 0;
      for (int i = 1; i <= 30; i++) ndone += int'(o_done[i]);
      for (int k = 0; k < 3; k++) begin
         pat = '0;
         for (int j = 1; j <= 8; j++) pat = {pat[6:0], o_tri[8*k + j]};
         chk({tag, " tri_pattern"}, int'(pat), 8'b1110_0000);
         chk({tag, " sel_chan"}, int'(o_sel[8*k + 1]), 1 + k);
      end
      chk({tag, " done_at_25"}, int'(o_done[25]), 1);
      chk({tag, " done_count"}, ndone, 1);
      chk({tag, " busy_24"}, int'(o_busy[24]), 1);
      chk({tag, " busy_25"}, int'(o_busy[25]), 0);
   endtask

   initial begin
      int ndone;
      bus.start = 0; bus.stop = 0; bus.cfg_first = 0; bus.cfg_last = 0;
      bus.cfg_settle = 0; bus.cfg_dwell = 0; bus.cfg_continuous = 0;
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle sel", int'(bus.sel), 0);
         chk("idle tri", int'(bus.tristate), 1);
         chk("idle busy/done/err", int'({bus.busy, bus.done, bus.cfg_err}), 0);
      end

      do_start(1, 3, 2, 4, 0, 0);
      capture(30, 0, 0);
      check_one_shot("oneshot");

      do_start(1, 3, 2, 4, 1, 0);
      capture(45, 40, 0);
      ndone = 0;
      for (int i = 1; i <= 45; i++) ndone += int'(o_done[i]);
      chk("cont sel_24", int'(o_sel[24]), 3);
      chk("cont tri_24", int'(o_tri[24]), 0);
      chk("cont wrap sel_25", int'(o_sel[25]), 1);
      chk("cont wrap tri_25", int'(o_tri[25]), 1);
      chk("cont busy_40", int'(o_busy[40]), 1);
      chk("stop busy_41", int'(o_busy[41]), 0);
      chk("stop tri_41", int'(o_tri[41]), 1);
      chk("stop sel_hold", int'(o_sel[41]), int'(o_sel[40]));
      chk("stop no done", ndone, 0);

      do_start(3, 1, 2, 4, 0, 0);
      capture(3, 0, 0);
      chk("err first>last pulse", int'(o_err[1]), 1);
      chk("err first>last width", int'(o_err[2]), 0);
      chk("err first>last busy", int'(o_busy[1]), 0);

      do_start(1, N, 2, 4, 0, 0);
      capture(3, 0, 0);
      chk("err last=N pulse", int'(o_err[1]), 1);
      chk("err last=N width", int'(o_err[2]), 0);
      chk("err last=N busy", int'(o_busy[1]), 0);

      do_start(1, 3, 2, 4, 0, 1);
      capture(3, 0, 0);
      chk("start+stop busy", int'(o_busy[1] | o_busy[2]), 0);

      do_start(1, 3, 2, 4, 0, 0);
      capture(30, 0, 5);
      check_one_shot("start_in_dwell");

      do_start(1, 3, 2, 4, 0, 0);
      capture(6, 0, 0);
      #2 reset = 1'b1;
      #1;
      chk("async rst tri", int'(bus.tristate), 1);
      chk("async rst sel", int'(bus.sel), 0);
      chk("async rst busy", int'(bus.busy), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      do_start(1, 3, 2, 4, 0, 0);
      capture(30, 0, 0);
      check_one_shot("after_reset");

      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         bus.cfg_first      = 4'($urandom_range(0, 4));
         bus.cfg_last       = 4'($urandom_range(0, 4));
         bus.cfg_settle     = 16'($urandom_range(0, 3));
         bus.cfg_dwell      = 16'($urandom_range(0, 3));
         bus.cfg_continuous = 1'($urandom_range(0, 1));
         bus.start          = ($urandom_range(0, 5) == 0);
         bus.stop           = ($urandom_range(0, 59) == 0);
      end
      @(negedge clk);
      bus.start = 1'b0; bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Sequencer that drives the select and tristate controls of an N-input data mux. It steps the select through a configured channel range with programmable settle (tristate guard) and dwell intervals, giving break-before-make switching so the mux output is never driven while its select is changing. It sits between the register-decode layer, which supplies the configuration, start and stop, and the mux datapath, which consumes `sel` and `tristate`.

## Interface
- `N_INPUTS`, 2: number of mux inputs; legal channel indices are 0..N_INPUTS-1.
- `SEL_WIDTH`, 4: width of the channel index and select fields.
- `CNT_WIDTH`, 16: width of the settle and dwell counts.
- `clk` input 1: sole clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: single-cycle request to begin a scan; sampled only in IDLE.
- `stop` input 1: single-cycle abort request; takes priority over `start`.
- `cfg_first` input SEL_WIDTH: first channel of the scan range.
- `cfg_last` input SEL_WIDTH: last channel of the scan range.
- `cfg_settle` input CNT_WIDTH: settle length; each settle lasts cfg_settle+1 cycles.
- `cfg_dwell` input CNT_WIDTH: dwell length; each dwell lasts cfg_dwell+1 cycles.
- `cfg_continuous` input 1: 1 = wrap from last back to first indefinitely; 0 = one pass.
- `sel` output SEL_WIDTH: registered mux select.
- `tristate` output 1: registered; 1 = mux output disabled.
- `chan_valid` output 1: registered; 1 while a channel is driven (DWELL state).
- `busy` output 1: registered; 1 in SETTLE or DWELL.
- `done` output 1: one-cycle pulse at the end of a one-shot pass.
- `cfg_err` output 1: one-cycle pulse when a `start` is rejected.

## Operation
- States:
  - IDLE: tristate=1, chan_valid=0, busy=0.
  - SETTLE: tristate=1, sel is the current channel, busy=1.
  - DWELL: tristate=0, chan_valid=1, busy=1.
- Configuration is latched on an accepted `start` and held for the whole scan. Changes to the cfg_* inputs during a scan have no effect.
- IDLE with `start` and no `stop`:
  - If cfg_first > cfg_last or cfg_last ≥ N_INPUTS: pulse cfg_err and stay in IDLE.
  - Otherwise: sel←cfg_first, enter SETTLE, load the counter with cfg_settle.
- SETTLE: the counter decrements each cycle. When it reaches 0, enter DWELL and load the counter with cfg_dwell.
- DWELL: the counter decrements each cycle. When it reaches 0:
  - If sel≠last: sel←sel+1, enter SETTLE.
  - If sel=last and continuous: sel←first, enter SETTLE.
  - If sel=last and one-shot: enter IDLE and pulse done.
- sel changes only on the transition into SETTLE, while tristate is already 1 or is becoming 1 in that same cycle. This guarantees that tristate=0 never coincides with a select change.
- `stop` in any state: enter IDLE on the next edge with tristate=1. No done pulse. sel holds its last value.
- `start` in SETTLE or DWELL is ignored.
- first = last: a single channel is cycled through settle and dwell; in continuous mode it re-settles every period.
- `reset` asserted at any time, including mid-scan, forces: IDLE, sel=0, tristate=1, chan_valid=0, busy=0, done=0, cfg_err=0, counter=0.

## Timing
- Reset values of all outputs are as listed under Operation.
- `start` accepted at edge E: at E+1, busy=1, sel=first, tristate=1.
- A settle spans cfg_settle+1 cycles; a dwell spans cfg_dwell+1 cycles.
- A one-shot pass over K channels occupies K·(settle+dwell+2) cycles. `done` is high on the first IDLE cycle and busy drops to 0 in that same cycle.
- `stop` at edge E: tristate=1 and busy=0 at E+1.
- cfg_err appears at E+1 after the rejected `start`.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package `mux_seq_pkg` holds:
  - the state enum {IDLE, SETTLE, DWELL};
  - a packed `mux_seq_cfg_t` struct {first, last, settle, dwell, continuous};
  - the reset-value constants.
- One natural sub-module, `interval_counter`: a loadable down-counter with a zero flag, shared by the SETTLE and DWELL states.

## Test plan
- Reset released, then hold idle for 10 cycles: sel=0, tristate=1, busy=0, done=0, cfg_err=0 throughout.
- Configuration N_INPUTS=4, first=1, last=3, settle=2, dwell=4, one-shot, `start` at cycle 0:
  - sel sequence is 1,2,3;
  - each channel shows 3 cycles of tristate=1 followed by 5 cycles of tristate=0;
  - done pulses at cycle 25, and busy=0 from cycle 25.
- Same configuration in continuous mode:
  - after channel 3's dwell, sel returns to 1 with tristate=1 first;
  - `stop` at cycle 40 gives tristate=1 and busy=0 at cycle 41, with no done pulse.
- Configuration first=3, last=1, `start`: cfg_err pulses for one cycle, busy stays 0. Repeat with last=N_INPUTS: same result.
- `start` and `stop` in the same cycle while IDLE: no scan begins. `start` during DWELL: ignored, and the scan sequence is unchanged.
- `reset` asserted asynchronously in the middle of a DWELL: tristate=1, sel=0 and busy=0 immediately, with no clock edge required. After release, a new `start` scans normally.
